// File: rtl/mfp_uart_transmitter.sv
// mfp_uart_transmitter: FIFO-buffered UART transmitter, 8N1 by default.
// Define MFP_UART_TX_PARITY_EN to add an even parity bit (8E1 frame).
module mfp_uart_transmitter #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [7:0]                  byte_data,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef MFP_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef MFP_UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic            push;
  logic            pop;
  logic            empty;
  logic            bit_done;
  logic [7:0]      head;

  assign byte_ready = (count_q != FULL);
  assign push       = byte_valid && byte_ready;
  assign empty      = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign bit_done   = (baud_q == BAUD_LAST);

  assign tx         = tx_q;
  assign busy       = !empty || (state_q != IDLE);
  assign fifo_count = count_q;

  // FIFO pointer and occupancy update; push and pop may coincide
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer; tx_d is the line level for the current state,
  // so the registered line trails the state by one cycle
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
`ifdef MFP_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef MFP_UART_TX_PARITY_EN
          par_d   = ^head;
`endif
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef MFP_UART_TX_PARITY_EN
      PARITY: begin
        tx_d = par_q;
        if (bit_done) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef MFP_UART_TX_PARITY_EN
            par_d   = ^head;
`endif
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State, counters, pointers and line register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef MFP_UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef MFP_UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clock) begin
    if (!reset && push) mem_q[wr_ptr_q] <= byte_data;
  end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// tb_mfp_uart_transmitter: directed and randomized checks of the UART
// transmitter against a bit-level frame model, default and fast baud.
module tb_mfp_uart_transmitter;

  localparam int CPB_A = 434;
  localparam int CPB_B = 8;
`ifdef MFP_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk;
  logic       rst_a, rst_b;
  logic [7:0] da, db;
  logic       va, vb;
  logic       ra, rb;
  logic       txa, txb;
  logic       busya, busyb;
  logic [4:0] cnta, cntb;

  int checks;
  int errors;

  mfp_uart_transmitter u_a (
    .clock      (clk),
    .reset      (rst_a),
    .byte_data  (da),
    .byte_valid (va),
    .byte_ready (ra),
    .tx         (txa),
    .busy       (busya),
    .fifo_count (cnta)
  );

  mfp_uart_transmitter #(
    .CLK_FREQ   (1000),
    .BAUD_RATE  (120),
    .FIFO_DEPTH (16)
  ) u_b (
    .clock      (clk),
    .reset      (rst_b),
    .byte_data  (db),
    .byte_valid (vb),
    .byte_ready (rb),
    .tx         (txb),
    .busy       (busyb),
    .fifo_count (cntb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic txs(input bit sel);
    return sel ? txb : txa;
  endfunction

  // Expected line: start 0, data LSB first, [even parity], stop 1.
  // w >= 0 demands exactly w idle samples before the start bit.
  task automatic check_frame(input bit sel, input logic [7:0] d,
                             input int w, input string tag);
    int n;
    int bad;
    int cpb;
    logic [10:0] bits;
    cpb = sel ? CPB_B : CPB_A;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef MFP_UART_TX_PARITY_EN
    bits[9] = ^d;
`endif
    n = 0;
    @(negedge clk);
    while (txs(sel) !== 1'b0 && n < 6000) begin
      n++;
      @(negedge clk);
    end
    if (w >= 0) chk({tag, "_gap"}, n, w);
    else        chk({tag, "_start"}, (n < 6000), 1);
    for (int b = 0; b < NBITS; b++) begin
      bad = 0;
      for (int s = 0; s < cpb; s++) begin
        if (b != 0 || s != 0) @(negedge clk);
        if (txs(sel) !== bits[b]) bad++;
      end
      chk($sformatf("%s_bit%0d", tag, b), bad, 0);
    end
  endtask

  task automatic reset_b();
    rst_b = 1'b1;
    vb    = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
  endtask

  logic [7:0] arr [18];
  int gaps [8];
  int pk;
  int lows;
  int k;

  initial begin
    checks = 0;
    errors = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    va = 1'b0; vb = 1'b0;
    da = 8'h00; db = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_a", txa, 1);
    chk("rst_busy_a", busya, 0);
    chk("rst_ready_a", ra, 1);
    chk("rst_cnt_a", cnta, 0);
    chk("rst_tx_b", txb, 1);
    chk("rst_busy_b", busyb, 0);
    chk("rst_ready_b", rb, 1);
    chk("rst_cnt_b", cntb, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // 'S' at the default baud, tx falls two edges after the push
    da = 8'h53; va = 1'b1;
    @(posedge clk);
    #1;
    va = 1'b0;
    chk("s53_busy", busya, 1);
    chk("s53_cnt", cnta, 1);
    check_frame(0, 8'h53, 2, "s53");
    @(negedge clk);
    chk("s53_idle_tx", txa, 1);
    chk("s53_idle_busy", busya, 0);
    chk("s53_idle_cnt", cnta, 0);

    // 0x07: three ones, parity bit 1 when enabled
    da = 8'h07; va = 1'b1;
    @(posedge clk);
    #1;
    va = 1'b0;
    check_frame(0, 8'h07, 2, "s07");
    @(negedge clk);
    chk("s07_idle_tx", txa, 1);

    // 16 consecutive pushes, back-to-back frames in order
    reset_b();
    pk = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          db = 8'(i); vb = 1'b1;
          @(posedge clk);
          #1;
          if (int'(cntb) > pk) pk = int'(cntb);
        end
        vb = 1'b0;
        chk("burst_peak", pk, 15);
        chk("burst_cnt_end", cntb, 15);
      end
      begin
        check_frame(1, 8'h00, -1, "burst0");
        for (int i = 1; i < 16; i++)
          check_frame(1, 8'(i), 0, $sformatf("burst%0d", i));
      end
    join
    @(negedge clk);
    chk("burst_idle_tx", txb, 1);
    chk("burst_idle_busy", busyb, 0);
    chk("burst_idle_cnt", cntb, 0);

    // Overflow: 16 queued plus one in flight, 0xAA refused
    reset_b();
    for (int i = 0; i < 17; i++) arr[i] = 8'($urandom);
    arr[17] = 8'h3C;
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          db = arr[i]; vb = 1'b1;
          @(posedge clk);
          #1;
        end
        chk("full_cnt", cntb, 16);
        chk("full_ready", rb, 0);
        db = 8'hAA;
        repeat (20) @(posedge clk);
        #1;
        vb = 1'b0;
        chk("full_cnt_hold", cntb, 16);
        k = 0;
        while (rb !== 1'b1 && k < 200) begin
          @(posedge clk);
          #1;
          k++;
        end
        chk("full_ready_back", rb, 1);
        chk("full_cnt_after_pop", cntb, 15);
        db = 8'h3C; vb = 1'b1;
        @(posedge clk);
        #1;
        vb = 1'b0;
        chk("full_cnt_refill", cntb, 16);
      end
      begin
        check_frame(1, arr[0], -1, "full0");
        for (int i = 1; i < 18; i++)
          check_frame(1, arr[i], 0, $sformatf("full%0d", i));
      end
    join
    @(negedge clk);
    chk("full_idle_tx", txb, 1);
    chk("full_idle_busy", busyb, 0);

    // Push coinciding with a pop at count 4
    reset_b();
    for (int i = 0; i < 5; i++) begin
      db = 8'($urandom); vb = 1'b1;
      @(posedge clk);
      #1;
    end
    vb = 1'b0;
    chk("pp_cnt_before", cntb, 4);
    repeat (76) @(posedge clk);
    #1;
    chk("pp_cnt_prepop", cntb, 4);
    db = 8'h5A; vb = 1'b1;
    @(posedge clk);
    #1;
    vb = 1'b0;
    chk("pp_cnt_same", cntb, 4);
    @(negedge clk);
    chk("pp_stop_tail", txb, 1);
    @(negedge clk);
    chk("pp_next_start", txb, 0);

    // Reset in the middle of data bit 3 with 5 bytes queued
    reset_b();
    for (int i = 0; i < 6; i++) begin
      db = 8'($urandom);
      if (i == 0) db[3] = 1'b0;
      vb = 1'b1;
      @(posedge clk);
      #1;
    end
    vb = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    chk("abort_mid_bit3", txb, 0);
    chk("abort_cnt_before", cntb, 5);
    rst_b = 1'b1; vb = 1'b1; db = 8'h99;
    @(posedge clk);
    #1;
    rst_b = 1'b0; vb = 1'b0;
    chk("abort_tx", txb, 1);
    chk("abort_cnt", cntb, 0);
    chk("abort_busy", busyb, 0);
    chk("abort_ready", rb, 1);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (txb !== 1'b1) lows++;
    end
    chk("abort_no_start", lows, 0);

    // Random bytes, random gaps, junk on byte_data between pushes
    for (int i = 0; i < 8; i++) begin
      arr[i]  = 8'($urandom);
      gaps[i] = $urandom_range(0, 120);
    end
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          repeat (gaps[i]) begin
            db = 8'($urandom);
            @(posedge clk);
            #1;
          end
          db = arr[i]; vb = 1'b1;
          @(posedge clk);
          #1;
          vb = 1'b0;
          db = 8'($urandom);
        end
      end
      begin
        for (int i = 0; i < 8; i++)
          check_frame(1, arr[i], -1, $sformatf("rnd%0d", i));
      end
    join
    @(negedge clk);
    chk("rnd_idle_busy", busyb, 0);
    chk("rnd_idle_cnt", cntb, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
